// File: rtl/resource_lock_arbiter.sv
// resource_lock_arbiter
// Shares NUM_RES identical resources among NUM_PORTS requesters. Each grant is a
// lock that binds a port and its issue ID to one resource until release or flush.
// Free resources are handed out round-robin over the ports, lowest-index resource
// first. All outputs come straight from flops.
module resource_lock_arbiter #(
  parameter int NUM_PORTS = 8,
  parameter int NUM_RES   = 8,
  parameter int ID_WIDTH  = 16,
  parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  parameter int RES_W     = (NUM_RES > 1) ? $clog2(NUM_RES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS*ID_WIDTH-1:0] req_id,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [NUM_PORTS*RES_W-1:0]    grant_res,
  output logic [NUM_RES-1:0]            res_busy,
  output logic [NUM_RES*PORT_W-1:0]     res_owner,
  output logic [RES_W:0]                free_count
);

  // Per-resource lock state
  logic [NUM_RES-1:0]  busy_q, busy_d;
  logic [PORT_W-1:0]   owner_port_q [NUM_RES];
  logic [PORT_W-1:0]   owner_port_d [NUM_RES];
  logic [ID_WIDTH-1:0] owner_id_q   [NUM_RES];
  logic [ID_WIDTH-1:0] owner_id_d   [NUM_RES];

  // Per-port lock state
  logic [NUM_PORTS-1:0] held_q, held_d;
  logic [RES_W-1:0]     held_res_q [NUM_PORTS];
  logic [RES_W-1:0]     held_res_d [NUM_PORTS];

  // Round-robin start point and free-resource count
  logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [RES_W:0]    free_count_q, free_count_d;

  // Next-state: flush beats release, release beats allocation. Allocation only
  // sees resources that were free before this edge, so a lock released now is
  // not handed out again until the following edge.
  always_comb begin
    logic [NUM_RES-1:0] avail;
    logic               any_grant;
    int                 last_port;
    int                 p;
    int                 busy_cnt;
    logic               found;
    int                 pick;

    busy_d     = busy_q;
    held_d     = held_q;
    rr_ptr_d   = rr_ptr_q;
    avail      = ~busy_q;
    any_grant  = 1'b0;
    last_port  = 0;
    p          = 0;
    busy_cnt   = 0;
    found      = 1'b0;
    pick       = 0;
    for (int r = 0; r < NUM_RES; r++) begin
      owner_port_d[r] = owner_port_q[r];
      owner_id_d[r]   = owner_id_q[r];
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      held_res_d[i] = held_res_q[i];
    end

    if (flush) begin
      // Rollback: every lock disappears; requests this cycle are ignored.
      busy_d = '0;
      held_d = '0;
    end else begin
      // Release locks whose requester dropped or whose SIC now carries a new ID.
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (held_q[i] &&
            (!req_valid[i] ||
             (req_id[i*ID_WIDTH +: ID_WIDTH] != owner_id_q[held_res_q[i]]))) begin
          held_d[i]                 = 1'b0;
          busy_d[held_res_q[i]]     = 1'b0;
        end
      end

      // Round-robin allocation from rr_ptr; ports held at the start of the
      // cycle (including those just released) do not compete this edge.
      for (int i = 0; i < NUM_PORTS; i++) begin
        p = int'(rr_ptr_q) + i;
        if (p >= NUM_PORTS) p = p - NUM_PORTS;
        if (req_valid[p] && !held_q[p]) begin
          found = 1'b0;
          pick  = 0;
          for (int r = NUM_RES - 1; r >= 0; r--) begin
            if (avail[r]) begin
              found = 1'b1;
              pick  = r;
            end
          end
          if (found) begin
            avail[pick]        = 1'b0;
            busy_d[pick]       = 1'b1;
            owner_port_d[pick] = PORT_W'(p);
            owner_id_d[pick]   = req_id[p*ID_WIDTH +: ID_WIDTH];
            held_d[p]          = 1'b1;
            held_res_d[p]      = RES_W'(pick);
            any_grant          = 1'b1;
            last_port          = p;
          end
        end
      end

      if (any_grant) begin
        rr_ptr_d = (last_port + 1 >= NUM_PORTS) ? '0 : PORT_W'(last_port + 1);
      end
    end

    for (int r = 0; r < NUM_RES; r++) begin
      if (busy_d[r]) busy_cnt = busy_cnt + 1;
    end
    free_count_d = (RES_W + 1)'(NUM_RES - busy_cnt);
  end

  // State registers; reset drops every lock immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      held_q       <= '0;
      rr_ptr_q     <= '0;
      free_count_q <= (RES_W + 1)'(NUM_RES);
      for (int r = 0; r < NUM_RES; r++) begin
        owner_port_q[r] <= '0;
        owner_id_q[r]   <= '0;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        held_res_q[i] <= '0;
      end
    end else begin
      busy_q       <= busy_d;
      held_q       <= held_d;
      rr_ptr_q     <= rr_ptr_d;
      free_count_q <= free_count_d;
      for (int r = 0; r < NUM_RES; r++) begin
        owner_port_q[r] <= owner_port_d[r];
        owner_id_q[r]   <= owner_id_d[r];
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        held_res_q[i] <= held_res_d[i];
      end
    end
  end

  // Flatten registered state onto the output buses.
  always_comb begin
    grant      = held_q;
    res_busy   = busy_q;
    free_count = free_count_q;
    grant_res  = '0;
    res_owner  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant_res[i*RES_W +: RES_W] = held_res_q[i];
    end
    for (int r = 0; r < NUM_RES; r++) begin
      res_owner[r*PORT_W +: PORT_W] = owner_port_q[r];
    end
  end

endmodule

// File: tb/tb_resource_lock_arbiter.sv
// Bench for resource_lock_arbiter: three instances (8, 2 and 1 resources) driven
// by directed steps; expected values are queued when stimulus is applied and
// compared once the outputs have settled after the next clock edge.
module tb_resource_lock_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance with 8 resources
  logic         flush8 = 1'b0;
  logic [7:0]   req8 = '0;
  logic [127:0] id8 = '0;
  logic [7:0]   grant8;
  logic [23:0]  gres8;
  logic [7:0]   busy8;
  logic [23:0]  owner8;
  logic [3:0]   free8;

  // Instance with 2 resources
  logic         flush2 = 1'b0;
  logic [7:0]   req2 = '0;
  logic [127:0] id2 = '0;
  logic [7:0]   grant2;
  logic [7:0]   gres2;
  logic [1:0]   busy2;
  logic [5:0]   owner2;
  logic [1:0]   free2;

  // Instance with 1 resource
  logic         flush1 = 1'b0;
  logic [7:0]   req1 = '0;
  logic [127:0] id1 = '0;
  logic [7:0]   grant1;
  logic [7:0]   gres1;
  logic [0:0]   busy1;
  logic [2:0]   owner1;
  logic [1:0]   free1;

  resource_lock_arbiter #(.NUM_PORTS(8), .NUM_RES(8), .ID_WIDTH(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8), .req_valid(req8), .req_id(id8),
    .grant(grant8), .grant_res(gres8), .res_busy(busy8), .res_owner(owner8),
    .free_count(free8));

  resource_lock_arbiter #(.NUM_PORTS(8), .NUM_RES(2), .ID_WIDTH(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .req_valid(req2), .req_id(id2),
    .grant(grant2), .grant_res(gres2), .res_busy(busy2), .res_owner(owner2),
    .free_count(free2));

  resource_lock_arbiter #(.NUM_PORTS(8), .NUM_RES(1), .ID_WIDTH(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .req_valid(req1), .req_id(id1),
    .grant(grant1), .grant_res(gres1), .res_busy(busy1), .res_owner(owner1),
    .free_count(free1));

  // Scoreboard entry: which output to look at and the value it must have.
  typedef enum int {
    S_GRANT8, S_BUSY8, S_FREE8, S_GRES8,
    S_GRANT2, S_BUSY2, S_FREE2, S_GRES2, S_OWNER2,
    S_GRANT1, S_FREE1
  } sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic push(input string tag, input sel_e sel, input int idx, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.idx = idx; e.val = val;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] observe(input sel_e sel, input int idx);
    logic [31:0] o;
    o = '0;
    case (sel)
      S_GRANT8: o = {24'b0, grant8};
      S_BUSY8:  o = {24'b0, busy8};
      S_FREE8:  o = {28'b0, free8};
      S_GRES8:  o = {29'b0, gres8[idx*3 +: 3]};
      S_GRANT2: o = {24'b0, grant2};
      S_BUSY2:  o = {30'b0, busy2};
      S_FREE2:  o = {30'b0, free2};
      S_GRES2:  o = {31'b0, gres2[idx]};
      S_OWNER2: o = {29'b0, owner2[idx*3 +: 3]};
      S_GRANT1: o = {24'b0, grant1};
      S_FREE1:  o = {30'b0, free1};
      default:  o = 'x;
    endcase
    return o;
  endfunction

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.sel, e.idx);
      n_total++;
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int n;
    int p;

    // Reset, then idle
    repeat (2) @(negedge clk);
    push("rst_grant8", S_GRANT8, 0, 32'h0);
    push("rst_busy8",  S_BUSY8,  0, 32'h0);
    push("rst_free8",  S_FREE8,  0, 32'd8);
    push("rst_free2",  S_FREE2,  0, 32'd2);
    push("rst_free1",  S_FREE1,  0, 32'd1);
    check_all();
    rst_n = 1'b1;
    push("idle_grant8", S_GRANT8, 0, 32'h0);
    push("idle_free8",  S_FREE8,  0, 32'd8);
    step();

    // Two resources: ports 0,3,5 request together
    id2[0*16 +: 16] = 16'd10;
    id2[3*16 +: 16] = 16'd11;
    id2[5*16 +: 16] = 16'd12;
    req2 = 8'b0010_1001;
    push("p2_grant",   S_GRANT2, 0, 32'h09);
    push("p2_gres0",   S_GRES2,  0, 32'd0);
    push("p2_gres3",   S_GRES2,  3, 32'd1);
    push("p2_free",    S_FREE2,  0, 32'd0);
    push("p2_busy",    S_BUSY2,  0, 32'h3);
    step();

    // Port 0 releases; resource 0 sits idle for one cycle
    req2[0] = 1'b0;
    push("rel0_grant", S_GRANT2, 0, 32'h08);
    push("rel0_busy",  S_BUSY2,  0, 32'h2);
    push("rel0_free",  S_FREE2,  0, 32'd1);
    step();
    push("p5_grant",   S_GRANT2, 0, 32'h28);
    push("p5_gres",    S_GRES2,  5, 32'd0);
    push("p5_owner",   S_OWNER2, 0, 32'd5);
    push("p5_free",    S_FREE2,  0, 32'd0);
    step();

    // Port 3 reused with a new issue ID while still requesting
    id2[3*16 +: 16] = 16'd20;
    push("reuse_grant", S_GRANT2, 0, 32'h20);
    push("reuse_busy",  S_BUSY2,  0, 32'h1);
    push("reuse_free",  S_FREE2,  0, 32'd1);
    step();
    push("regrant_grant", S_GRANT2, 0, 32'h28);
    push("regrant_gres3", S_GRES2,  3, 32'd1);
    push("regrant_owner", S_OWNER2, 1, 32'd3);
    step();
    push("id20_kept", S_GRANT2, 0, 32'h28);
    step();
    req2 = '0;
    step();

    // One resource, all ports requesting: grants must rotate 0..7 then 0
    req1 = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      p = k % 8;
      n = 0;
      do begin
        @(posedge clk);
        @(negedge clk);
        n++;
      end while (grant1 == 8'h0 && n < 10);
      push($sformatf("rr_grant_k%0d", k), S_GRANT1, 0, 32'(1 << p));
      check_all();
      @(posedge clk);
      @(negedge clk);
      req1[p] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req1[p] = 1'b1;
    end
    req1 = '0;
    step();

    // Flush with three locks held and two new requests arriving
    for (int i = 0; i < 8; i++) id8[i*16 +: 16] = 16'(100 + i);
    req8 = 8'b0001_0110;
    push("pre_grant", S_GRANT8, 0, 32'h16);
    push("pre_free",  S_FREE8,  0, 32'd5);
    push("pre_gres4", S_GRES8,  4, 32'd2);
    step();
    req8   = 8'b1101_0110;
    flush8 = 1'b1;
    push("flush_grant", S_GRANT8, 0, 32'h0);
    push("flush_busy",  S_BUSY8,  0, 32'h0);
    push("flush_free",  S_FREE8,  0, 32'd8);
    step();
    flush8 = 1'b0;
    push("post_grant", S_GRANT8, 0, 32'hD6);
    push("post_free",  S_FREE8,  0, 32'd3);
    push("post_gres6", S_GRES8,  6, 32'd0);
    push("post_gres1", S_GRES8,  1, 32'd2);
    step();

    // Asynchronous reset in the middle of a tenure
    #2;
    rst_n = 1'b0;
    #1;
    push("async_grant", S_GRANT8, 0, 32'h0);
    push("async_busy",  S_BUSY8,  0, 32'h0);
    push("async_free",  S_FREE8,  0, 32'd8);
    check_all();
    req8 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/resource_lock_arbiter.md
Name: resource_lock_arbiter

Overview:
Shares a pool of NUM_RES identical execution resources (ALU slots, memory banks) among NUM_PORTS single-instruction controllers. A grant is a lock: it binds one requester, identified by port and issue ID, to one resource until release or flush. Allocation is round-robin. The block sits between the SIC array and a resource pool and drives the pool's per-resource ownership.

Parameters:
NUM_PORTS, 8, number of requesting SICs
NUM_RES, 8, number of pooled resources (1..NUM_PORTS)
ID_WIDTH, 16, issue-ID width
PORT_W, derived $clog2(NUM_PORTS) (min 1), port index width
RES_W, derived $clog2(NUM_RES) (min 1), resource index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  rollback: drop every lock
req_valid  in  NUM_PORTS  level request per port; held high for the whole lock tenure
req_id  in  NUM_PORTS*ID_WIDTH  issue ID of the requesting instruction, per port
grant  out  NUM_PORTS  registered; high while the port owns a resource
grant_res  out  NUM_PORTS*RES_W  index of the owned resource; valid only when grant[p]
res_busy  out  NUM_RES  registered; resource is locked
res_owner  out  NUM_RES*PORT_W  owning port per resource; valid only when res_busy[r]
free_count  out  RES_W+1  number of unlocked resources (registered)

Behaviour:
- Reset (async, rst_n=0):
  - grant, grant_res, res_busy, res_owner and all stored owner IDs go to 0.
  - free_count = NUM_RES; rr_ptr = 0.
- State per resource: busy, owner_port, owner_id. Per port: held, held_res. rr_ptr of width PORT_W.
- Each rising edge, in priority order:
  1. flush=1:
     - Clear all locks; grant=0 and res_busy=0 next cycle; free_count=NUM_RES.
     - Requests in that cycle are ignored. rr_ptr is unchanged.
  2. Release, for every held port p:
     - Lock is freed if req_valid[p]=0, or if req_id[p] differs from its resource's owner_id (the SIC was reused).
     - grant[p] drops next cycle.
  3. Allocation:
     - Uses the free set registered before this edge, so a resource freed this edge is not reusable until the next edge (one-cycle bubble).
     - Scan ports rr_ptr, rr_ptr+1, … mod NUM_PORTS.
     - Each port with req_valid=1 and not held (including ports released this edge, which re-arbitrate only from the next edge) takes the lowest-index free resource.
     - Scanning stops when free resources are exhausted.
     - owner_id latches req_id[p].
  4. rr_ptr moves to (last port granted this edge + 1) mod NUM_PORTS. It is unchanged if nothing was granted.
- Latency: request sampled at edge t gives grant=1 from edge t (visible cycle t+1), if a resource is free.
- Grant holding:
  - grant_res is stable for the whole tenure.
  - A port never holds two resources.
  - A resource never has two owners.
- Invariants:
  - free_count = NUM_RES − popcount(res_busy).
  - popcount(grant) = popcount(res_busy).
- Full pool: waiting requesters stay ungranted with no timeout. Fairness is guaranteed by rr_ptr, so every continuous requester is granted within NUM_PORTS grant events.
- Simultaneous release and request on the same resource: the resource goes to the new requester one cycle later (bubble above).
- Reset mid-tenure drops all locks immediately and asynchronously.
- Combinational paths: none from inputs to outputs; all outputs are flops.

Test Plan:
- Reset then idle: grant=0, res_busy=0, free_count=8, rr_ptr=0.
- NUM_RES=2; ports 0,3,5 raise req in the same cycle (ids 10,11,12) → next cycle:
  - grant=0b0000_1001, grant_res[0]=0, grant_res[3]=1, free_count=0.
  - Port 5 waits; rr_ptr=4.
- Continuing: port 0 drops req → next cycle grant[0]=0, res_busy[0]=0. Following cycle grant[5]=1, grant_res[5]=0, res_owner[0]=5.
- Port 3 holds with id 11, then req_id changes to 20 with req_valid still 1:
  - Cycle+1: grant[3]=0, resource 1 free.
  - Cycle+2: port 3 regranted with owner_id=20.
- Fairness, NUM_RES=1: all 8 ports request continuously, each drops req 2 cycles after its grant → grants rotate in order 0,1,2,…,7,0 with no port skipped.
- flush asserted while 3 locks are held and 2 new requests arrive → next cycle grant=0, free_count=8, no new grant that cycle. Requests still high are granted on the following edge.
